mapper_fill_scheduler: RTL and testbench
========================================

// Module: mapper_fill_scheduler
// PURPOSE
//  Sequences the mapper's filling shift register: per cycle, drives its consume count c with the
//  bits-per-symbol of the selected modulation. Tracks the register's fill level and the frame bit budget.
//  Stalls on empty input FIFO or downstream backpressure. Flags the frame's last symbol.
//  Sits between the frame-control logic and the filling shift register / symbol mapper.
// PARAMETERS
//  MAPPER_PARALLELISM  8   shift-register word width, in bits; also the FIFO word width
//  FRAME_LEN_W         16  width of the frame_bits input
// PORTS
//  clk                  in   1            clock; all logic is on the rising edge
//  reset                in   1            synchronous, active-low reset
//  start                in   1            one-cycle frame start; sampled only in IDLE
//  abort                in   1            terminate the frame; return to IDLE
//  mod_sel              in   2            00=BPSK(1) 01=QPSK(2) 10=16QAM(4) 11=64QAM(6); latched on start
//  frame_bits           in   FRAME_LEN_W  frame length in bits; latched on start; 0 is illegal
//  fifo_empty           in   1            input data FIFO is empty
//  data_in_fifo_rd_req  in   1            read request issued by the filling shift register
//  out_ready            in   1            symbol mapper can accept a symbol this cycle
//  c                    out  $clog2(MAPPER_PARALLELISM)  bits consumed this cycle; 0 = hold
//  sym_valid            out  1            a symbol is emitted this cycle (c != 0)
//  sym_last             out  1            the emitted symbol is the last symbol of the frame
//  sym_pad              out  1            the last symbol is partial (valid only with PAD_LAST_EN)
//  busy                 out  1            state != IDLE
//  frame_done           out  1            one-cycle pulse when the frame completes
//  frame_err            out  1            sticky error; cleared by start or reset
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE; c=0; all flags=0; bits_avail=0; bits_rem=0.
//   Reset overrides any in-flight frame.
//  Word refill: a word is loaded when data_in_fifo_rd_req & ~fifo_empty.
//   bits_avail += MAPPER_PARALLELISM one cycle after the load.
//   bits_avail -= c in the same cycle that c is driven.
//   Refill and consume in the same cycle are summed.
//  Capacity: bits_avail > 2*MAPPER_PARALLELISM sets frame_err. The counter saturates; it never wraps.
//  States:
//   IDLE -> PRIME on start. PRIME latches bps, sets bits_rem=frame_bits, clears frame_err.
//    start with frame_bits==0: frame_err=1, stay in IDLE.
//   PRIME -> RUN once bits_avail >= bps.
//   RUN: c=bps, sym_valid=1 when bits_avail>=bps, out_ready=1 and bits_rem>=bps; otherwise c=0 (stall).
//    Each symbol decrements bits_rem by bps.
//    The symbol that brings bits_rem to 0 has sym_last=1; transition to DONE.
//   DONE: frame_done=1 for one cycle; discard the residual bits_avail; -> IDLE.
//   abort (any state except IDLE): c=0 that cycle; -> IDLE the next cycle; no frame_done.
//  Timing: c, sym_valid and sym_last are registered. First c!=0 appears >= 2 cycles after start.
//  Priority: reset > abort > start. start while busy is ignored.
//  bps must be < MAPPER_PARALLELISM. bps >= MAPPER_PARALLELISM at start sets frame_err and stays in IDLE.
// CONFIGURATION
//  MAPPER_PAD_LAST_EN defined:
//   If 0 < bits_rem < bps, emit a final symbol with c=bits_rem, sym_last=1, sym_pad=1.
//  MAPPER_PAD_LAST_EN undefined:
//   sym_pad is tied to 0. If 0 < bits_rem < bps: frame_err=1, no symbol, -> DONE.
// STRUCTURE
//  Shared package mapper_pkg:
//   mod_sel encoding constants and function bps_of(mod_sel).
//   Scheduler state enum {IDLE,PRIME,RUN,DONE}.
//   Localparam CNT_W = $clog2(2*MAPPER_PARALLELISM)+1.
//  One sub-module, mapper_fill_tracker: bits_avail counter with refill/consume/saturate and overflow flag.
// TESTING (P=8, FRAME_LEN_W=16)
//  1 QPSK: frame_bits=16, FIFO never empty, out_ready=1
//     -> 8 cycles of c=2; sym_last on the 8th; frame_done one cycle later.
//  2 16QAM: frame_bits=32, fifo_empty=1 for 5 cycles mid-frame
//     -> c=0 while bits_avail<4; resume with c=4; exactly 8 symbols.
//  3 BPSK: frame_bits=8, out_ready toggles 1/0
//     -> c=1 only on ready cycles; 8 symbols; no bit lost or duplicated.
//  4 64QAM: frame_bits=20
//     -> PAD_EN: 3x c=6, then c=2 with sym_pad=1 and sym_last=1.
//     -> no PAD_EN: 3x c=6, then frame_err=1 and frame_done.
//  5 abort in RUN after 3 symbols, then restart with QPSK, frame_bits=4
//     -> busy drops within 1 cycle; new frame gives 2x c=2.
//  6 reset low mid-frame; start with frame_bits=0
//     -> all outputs 0 after reset; second start gives frame_err=1, stays IDLE.

Source files
------------

// File: rtl/mapper_pkg.sv
// rtl/mapper_pkg.sv - shared modulation constants, scheduler states and counter sizing
package mapper_pkg;

    localparam logic [1:0] MOD_BPSK  = 2'b00;
    localparam logic [1:0] MOD_QPSK  = 2'b01;
    localparam logic [1:0] MOD_16QAM = 2'b10;
    localparam logic [1:0] MOD_64QAM = 2'b11;

    localparam int MAPPER_PARALLELISM_DEFAULT = 8;
    localparam int CNT_W = $clog2(2 * MAPPER_PARALLELISM_DEFAULT) + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} sched_state_e;

    function automatic int unsigned bps_of(input logic [1:0] mod_sel);
        case (mod_sel)
            MOD_BPSK:  return 1;
            MOD_QPSK:  return 2;
            MOD_16QAM: return 4;
            default:   return 6;
        endcase
    endfunction

    // Fill counter width for a given word width: holds 2*P plus one bit of headroom.
    function automatic int cnt_width(input int p);
        return $clog2(2 * p) + 1;
    endfunction

endpackage

// File: rtl/mapper_fill_tracker.sv
// rtl/mapper_fill_tracker.sv - shift-register fill counter with refill, consume, saturation and overflow flag
module mapper_fill_tracker
    import mapper_pkg::*;
#(
    parameter int P  = 8,
    parameter int CW = 3,
    parameter int AW = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] consume_i,
    input  logic          clear_i,
    output logic [AW-1:0] avail_o,
    output logic [AW-1:0] avail_next_o,
    output logic          overflow_o
);
    localparam int SAT   = (1 << AW) - 1;
    localparam int LIMIT = 2 * P;

    logic          load_q;
    logic [AW-1:0] avail_q;
    logic [AW-1:0] avail_d;
    logic [AW:0]   gross;
    logic [AW:0]   net;

    // A loaded word lands one cycle after its read; the consume of the cycle is subtracted in the same update.
    always_comb begin
        gross = {1'b0, avail_q} + (load_q ? (AW+1)'(P) : '0);
        if (gross < (AW+1)'(consume_i)) begin
            net = '0;
        end else begin
            net = gross - (AW+1)'(consume_i);
        end
        avail_d    = (net > (AW+1)'(SAT)) ? AW'(SAT) : net[AW-1:0];
        overflow_o = ~clear_i & (net > (AW+1)'(LIMIT));
    end

    // Counter and pending-load register; clear drops residual bits between frames.
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_q  <= 1'b0;
            avail_q <= '0;
        end else begin
            load_q  <= load_i;
            avail_q <= clear_i ? '0 : avail_d;
        end
    end

    assign avail_o      = avail_q;
    assign avail_next_o = avail_d;

endmodule

// File: rtl/mapper_fill_scheduler.sv
// rtl/mapper_fill_scheduler.sv - per-cycle consume-count scheduler for the mapper shift register (option: MAPPER_PAD_LAST_EN)
module mapper_fill_scheduler
    import mapper_pkg::*;
#(
    parameter int MAPPER_PARALLELISM = 8,
    parameter int FRAME_LEN_W        = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [1:0]                            mod_sel,
    input  logic [FRAME_LEN_W-1:0]                frame_bits,
    input  logic                                  fifo_empty,
    input  logic                                  data_in_fifo_rd_req,
    input  logic                                  out_ready,
    output logic [$clog2(MAPPER_PARALLELISM)-1:0] c,
    output logic                                  sym_valid,
    output logic                                  sym_last,
    output logic                                  sym_pad,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  frame_err
);
    localparam int CW = $clog2(MAPPER_PARALLELISM);
    localparam int AW = cnt_width(MAPPER_PARALLELISM);

    sched_state_e           state_q, state_d;
    logic [CW-1:0]          c_q, c_d;
    logic [CW-1:0]          bps_q, bps_d;
    logic [FRAME_LEN_W-1:0] rem_q, rem_d;
    logic                   last_q, last_d;
    logic                   pad_q, pad_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [AW-1:0]          avail;
    logic [AW-1:0]          avail_next;
    logic                   overflow;
    logic                   clear;

    assign clear = (state_q == IDLE) || (state_q == DONE);

    mapper_fill_tracker #(
        .P  (MAPPER_PARALLELISM),
        .CW (CW),
        .AW (AW)
    ) u_tracker (
        .clk          (clk),
        .reset        (reset),
        .load_i       (data_in_fifo_rd_req & ~fifo_empty),
        .consume_i    (c_q),
        .clear_i      (clear),
        .avail_o      (avail),
        .avail_next_o (avail_next),
        .overflow_o   (overflow)
    );

    // Next state and next registered outputs; symbol decisions use the fill level at the cycle c is driven.
    always_comb begin
        state_d = state_q;
        c_d     = '0;
        last_d  = 1'b0;
        pad_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q | overflow;
        rem_d   = rem_q;
        bps_d   = bps_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (frame_bits == '0 || bps_of(mod_sel) >= MAPPER_PARALLELISM) begin
                        err_d = 1'b1;
                    end else begin
                        bps_d   = CW'(bps_of(mod_sel));
                        rem_d   = frame_bits;
                        err_d   = 1'b0;
                        state_d = PRIME;
                    end
                end
            end
            PRIME: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (int'(avail) >= int'(bps_q)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (int'(rem_q) < int'(bps_q)) begin
`ifdef MAPPER_PAD_LAST_EN
                    if (int'(avail_next) >= int'(rem_q) && out_ready) begin
                        c_d     = CW'(rem_q);
                        last_d  = 1'b1;
                        pad_d   = 1'b1;
                        rem_d   = '0;
                        state_d = DONE;
                    end
`else
                    err_d   = 1'b1;
                    state_d = DONE;
`endif
                end else if (int'(avail_next) >= int'(bps_q) && out_ready) begin
                    c_d    = bps_q;
                    rem_d  = rem_q - FRAME_LEN_W'(bps_q);
                    last_d = (rem_d == '0);
                    if (last_d) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = ~abort;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            bps_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            bps_q   <= bps_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign c          = c_q;
    assign sym_valid  = (c_q != '0);
    assign sym_last   = last_q;
    assign sym_pad    = pad_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_mapper_fill_scheduler.sv
// tb/tb_mapper_fill_scheduler.sv - randomized self-checking bench for mapper_fill_scheduler
module tb_mapper_fill_scheduler;
    import mapper_pkg::*;

    localparam int P  = 8;
    localparam int FW = 16;
`ifdef MAPPER_PAD_LAST_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [1:0]    mod_sel;
    logic [FW-1:0] frame_bits;
    logic          fifo_empty;
    logic          data_in_fifo_rd_req;
    logic          out_ready;
    logic [2:0]    c;
    logic          sym_valid;
    logic          sym_last;
    logic          sym_pad;
    logic          busy;
    logic          frame_done;
    logic          frame_err;

    mapper_fill_scheduler #(
        .MAPPER_PARALLELISM (P),
        .FRAME_LEN_W        (FW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .abort               (abort),
        .mod_sel             (mod_sel),
        .frame_bits          (frame_bits),
        .fifo_empty          (fifo_empty),
        .data_in_fifo_rd_req (data_in_fifo_rd_req),
        .out_ready           (out_ready),
        .c                   (c),
        .sym_valid           (sym_valid),
        .sym_last            (sym_last),
        .sym_pad             (sym_pad),
        .busy                (busy),
        .frame_done          (frame_done),
        .frame_err           (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit last;
        bit pad;
    } sym_t;

    int n_err = 0;
    int n_chk = 0;
    int bps_tab [4] = '{1, 2, 4, 6};

    // Environment ledger: bits landed in the shift register, as seen from loads and observed consumes.
    int env_avail;
    bit env_pend;
    int c_cur;
    bit rd_drv;
    bit empty_drv;
    bit ready_prev;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        env_avail  = env_avail + (env_pend ? P : 0) - c_cur;
        env_pend   = rd_drv && !empty_drv;
        c_cur      = int'(c);
        ready_prev = out_ready;
    endtask

    task automatic drive(input bit empty_v, input bit ready_v, input bit fetch_en);
        fifo_empty = empty_v;
        out_ready  = ready_v;
        data_in_fifo_rd_req = fetch_en && ((env_avail + (env_pend ? P : 0) - c_cur) <= P);
        rd_drv    = data_in_fifo_rd_req;
        empty_drv = empty_v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            abort = 1'b0;
            drive(1'b0, 1'b1, 1'b0);
            tick();
            expect_eq("idle_busy", busy, 0);
            expect_eq("idle_c", c, 0);
            expect_eq("idle_done", frame_done, 0);
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input int bits, input int empty_from, input int empty_len,
                             input int ready_mode, input int empty_pct, input int abort_after, input bit need_consec);
        sym_t exp_q[$];
        sym_t e;
        int   b, n_full, r, total, nsym, sum, cyc, first_cyc, last_cyc, prev_cyc;
        bit   exp_err, done_seen, consec_ok, err_at_done, ev, rv;
        b      = bps_tab[m];
        n_full = bits / b;
        r      = bits % b;
        for (int i = 0; i < n_full; i++) begin
            e.c = b; e.last = (i == n_full - 1) && (r == 0); e.pad = 1'b0;
            exp_q.push_back(e);
        end
        if (r != 0 && PAD_EN) begin
            e.c = r; e.last = 1'b1; e.pad = 1'b1;
            exp_q.push_back(e);
        end
        exp_err = (r != 0) && !PAD_EN;
        total   = exp_q.size();

        start      = 1'b1;
        abort      = 1'b0;
        mod_sel    = m;
        frame_bits = FW'(bits);
        env_avail  = 0;
        env_pend   = 1'b0;
        c_cur      = 0;
        drive(1'b0, 1'b1, 1'b1);
        tick();
        start = 1'b0;
        expect_eq("start_busy", busy, 1);
        expect_eq("start_err_clr", frame_err, 0);

        cyc = 1; nsym = 0; sum = 0; first_cyc = -1; last_cyc = -1; prev_cyc = -1;
        done_seen = 1'b0; consec_ok = 1'b1; err_at_done = 1'b0;
        while (!done_seen && cyc < 400) begin
            expect_eq("valid", sym_valid, c != 0);
            if (c != 0) begin
                expect_eq("ready_gate", ready_prev, 1);
                expect_eq("ledger", int'(c) <= env_avail, 1);
                nsym++;
                sum += int'(c);
                if (first_cyc < 0) first_cyc = cyc;
                if (prev_cyc >= 0 && cyc != prev_cyc + 1) consec_ok = 1'b0;
                prev_cyc = cyc;
                if (exp_q.size() == 0) begin
                    expect_eq("extra_sym", nsym, total);
                end else begin
                    e = exp_q.pop_front();
                    expect_eq("sym_c", c, e.c);
                    expect_eq("sym_last", sym_last, e.last);
                    expect_eq("sym_pad", sym_pad, e.pad);
                    if (e.last) last_cyc = cyc;
                end
            end else begin
                expect_eq("last_no_sym", sym_last, 0);
            end
            if (frame_done) begin
                done_seen   = 1'b1;
                err_at_done = frame_err;
                expect_eq("done_busy", busy, 0);
                if (!exp_err && total > 0) expect_eq("done_lat", cyc, last_cyc + 1);
            end else if (abort_after >= 0 && nsym == abort_after) begin
                abort = 1'b1;
                drive(1'b0, 1'b1, 1'b1);
                tick();
                abort = 1'b0;
                expect_eq("abort_busy", busy, 0);
                expect_eq("abort_c", c, 0);
                idle(3);
                return;
            end else begin
                if (ready_mode == 0) rv = 1'b1;
                else if (ready_mode == 1) rv = (cyc % 2) == 0;
                else rv = $urandom_range(0, 99) < 75;
                if (cyc >= empty_from && cyc < empty_from + empty_len) ev = 1'b1;
                else ev = $urandom_range(0, 99) < empty_pct;
                drive(ev, rv, 1'b1);
                tick();
                cyc++;
            end
        end
        expect_eq("done_seen", done_seen, 1);
        expect_eq("sym_count", nsym, total);
        expect_eq("bits_sum", sum, n_full * b + (PAD_EN ? r : 0));
        expect_eq("frame_err", err_at_done, exp_err);
        if (nsym > 0) expect_eq("first_lat", first_cyc >= 2, 1);
        if (need_consec) expect_eq("consec", consec_ok, 1);
        idle(2);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; mod_sel = 2'b00; frame_bits = '0;
        env_avail = 0; env_pend = 1'b0; c_cur = 0; ready_prev = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        expect_eq("rst_c", c, 0);
        expect_eq("rst_valid", sym_valid, 0);
        expect_eq("rst_last", sym_last, 0);
        expect_eq("rst_pad", sym_pad, 0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", frame_done, 0);
        expect_eq("rst_err", frame_err, 0);
        reset = 1'b1;
        idle(2);

        run_frame(MOD_QPSK, 16, -1, 0, 0, 0, -1, 1'b1);
        run_frame(MOD_16QAM, 32, 4, 5, 0, 0, -1, 1'b0);
        run_frame(MOD_BPSK, 8, -1, 0, 1, 0, -1, 1'b0);
        run_frame(MOD_64QAM, 20, -1, 0, 0, 0, -1, 1'b0);
        run_frame(MOD_QPSK, 32, -1, 0, 0, 0, 3, 1'b0);
        run_frame(MOD_QPSK, 4, -1, 0, 0, 0, -1, 1'b0);

        start = 1'b1; mod_sel = MOD_QPSK; frame_bits = 16'd32;
        env_avail = 0; env_pend = 1'b0; c_cur = 0;
        drive(1'b0, 1'b1, 1'b1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        tick();
        expect_eq("mid_rst_c", c, 0);
        expect_eq("mid_rst_valid", sym_valid, 0);
        expect_eq("mid_rst_last", sym_last, 0);
        expect_eq("mid_rst_busy", busy, 0);
        expect_eq("mid_rst_done", frame_done, 0);
        expect_eq("mid_rst_err", frame_err, 0);
        reset = 1'b1;
        idle(2);
        start = 1'b1; mod_sel = MOD_QPSK; frame_bits = '0;
        drive(1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        expect_eq("zero_len_err", frame_err, 1);
        expect_eq("zero_len_busy", busy, 0);
        idle(2);
        expect_eq("zero_len_sticky", frame_err, 1);

        for (int k = 0; k < 24; k++) begin
            run_frame(2'($urandom_range(0, 3)), int'($urandom_range(1, 60)), -1, 0, 2, 25, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
